// File: rtl/fisr_job_scheduler.sv
// Round-robin front end that shares one fixed-latency FISR core among NUM_REQ requesters.
// A tag pipeline that runs alongside the core sends each result back to the requester that owns it.
module fisr_job_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int CORE_LAT = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      core_in_valid,
    output logic [DATA_W-1:0]         core_in_data,
    input  logic                      core_out_valid,
    input  logic [DATA_W-1:0]         core_out_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      idle,
    output logic                      err,
    output logic [31:0]               jobs_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] outstanding;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_hs;
    logic [IDX_W-1:0]   grant_idx;
    logic               found;
    logic [DATA_W-1:0]  req_word [NUM_REQ];

    logic [IDX_W-1:0]    ptr_reg;
    logic [IDX_W-1:0]    issue_idx_reg;
    logic                core_in_valid_reg;
    logic [DATA_W-1:0]   core_in_data_reg;
    logic [CORE_LAT-1:0] tag_v_reg;
    logic [IDX_W-1:0]    tag_idx_reg [CORE_LAT];
    logic                err_reg;
    logic [31:0]         jobs_done_reg;

    logic             head_v;
    logic [IDX_W-1:0] head_idx;

    assign head_v   = tag_v_reg[CORE_LAT-1];
    assign head_idx = tag_idx_reg[CORE_LAT-1];

    // Holding reset also masks grants so req_ready reads 0 while in reset.
    assign elig = req_valid & ~outstanding & {NUM_REQ{en & ARESETN}};

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && elig[(int'(ptr_reg) + k) % NUM_REQ]) begin
                found     = 1'b1;
                grant_idx = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
            end
        end
        grant = '0;
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign rsp_hs    = rsp_valid & rsp_ready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ptr_reg           <= IDX_W'(NUM_REQ - 1);
            issue_idx_reg     <= '0;
            core_in_valid_reg <= 1'b0;
            core_in_data_reg  <= '0;
            err_reg           <= 1'b0;
            jobs_done_reg     <= '0;
        end else begin
            core_in_valid_reg <= found;
            if (found) begin
                ptr_reg          <= grant_idx;
                issue_idx_reg    <= grant_idx;
                core_in_data_reg <= req_word[grant_idx];
            end
            if (core_out_valid ^ head_v) begin
                err_reg <= 1'b1;
            end
            jobs_done_reg <= jobs_done_reg + 32'($countones(rsp_hs));
        end
    end

    // Tag stage k lines up with core stage k, so the head tag describes core_out this cycle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tag_v_reg <= '0;
            for (int s = 0; s < CORE_LAT; s++) begin
                tag_idx_reg[s] <= '0;
            end
        end else begin
            tag_v_reg[0]   <= core_in_valid_reg;
            tag_idx_reg[0] <= issue_idx_reg;
            for (int s = 1; s < CORE_LAT; s++) begin
                tag_v_reg[s]   <= tag_v_reg[s-1];
                tag_idx_reg[s] <= tag_idx_reg[s-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic              rsp_valid_reg;
            logic [DATA_W-1:0] rsp_data_reg;
            logic              outstanding_reg;
            logic              ret_hit;

            assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
            assign ret_hit      = core_out_valid & head_v & (head_idx == IDX_W'(gi));

            // A returning result never meets a pending handshake for the same owner.
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    rsp_valid_reg   <= 1'b0;
                    rsp_data_reg    <= '0;
                    outstanding_reg <= 1'b0;
                end else begin
                    if (ret_hit) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= core_out_data;
                    end else if (rsp_hs[gi]) begin
                        rsp_valid_reg <= 1'b0;
                    end
                    if (grant[gi]) begin
                        outstanding_reg <= 1'b1;
                    end else if (rsp_hs[gi]) begin
                        outstanding_reg <= 1'b0;
                    end
                end
            end

            assign rsp_valid[gi]                   = rsp_valid_reg;
            assign rsp_data[gi*DATA_W +: DATA_W]   = rsp_data_reg;
            assign outstanding[gi]                 = outstanding_reg;
        end
    endgenerate

    assign core_in_valid = core_in_valid_reg;
    assign core_in_data  = core_in_data_reg;
    assign idle          = ~|outstanding;
    assign err           = err_reg;
    assign jobs_done     = jobs_done_reg;

endmodule

// File: tb/tb_fisr_job_scheduler.sv
// Scoreboard bench for fisr_job_scheduler with a 4-cycle bit-inverting core model.
module tb_fisr_job_scheduler;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         en = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         core_in_valid;
    logic [31:0]  core_in_data;
    logic         core_out_valid;
    logic [31:0]  core_out_data;
    logic [3:0]   rsp_valid;
    logic [127:0] rsp_data;
    logic [3:0]   rsp_ready = 4'hF;
    logic         idle;
    logic         err;
    logic [31:0]  jobs_done;

    fisr_job_scheduler #(.NUM_REQ(4), .DATA_W(32), .CORE_LAT(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .idle(idle), .err(err), .jobs_done(jobs_done)
    );

    always #5 ACLK = ~ACLK;

    // Core model: result = ~operand, 4 cycles later; deliberately not reset.
    logic [3:0]  pv = '0;
    logic [31:0] pd [4];
    always @(posedge ACLK) begin
        pv    <= {pv[2:0], core_in_valid};
        pd[0] <= ~core_in_data;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign core_out_valid = pv[3];
    assign core_out_data  = pd[3];

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_rsp [4][$];
    logic [3:0]  exp_grant [$];
    int          acc_cyc [4];
    logic [3:0]  rsp_valid_prev = '0;
    bit          grant_chk = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grant order, one-hot grants, result data and accept-to-result latency.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (req_ready != 4'b0) begin
                chk("grant_onehot", {31'b0, $onehot(req_ready)}, 32'd1);
                if (grant_chk) begin
                    if (exp_grant.size() == 0) chk("grant_unexpected", {28'b0, req_ready}, 32'd0);
                    else chk("grant_order", {28'b0, req_ready}, {28'b0, exp_grant.pop_front()});
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_rsp[i].push_back(~req_data[i*32 +: 32]);
                    acc_cyc[i] <= cyc;
                    $display("cycle %0d: grant req%0d operand %h", cyc, i, req_data[i*32 +: 32]);
                end
                if (rsp_valid[i] && !rsp_valid_prev[i])
                    chk("rsp_latency", 32'(cyc - acc_cyc[i]), 32'd6);
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (exp_rsp[i].size() == 0) chk("rsp_unexpected", {31'b0, rsp_valid[i]}, 32'd0);
                    else chk("rsp_data", rsp_data[i*32 +: 32], exp_rsp[i].pop_front());
                    $display("cycle %0d: result req%0d data %h", cyc, i, rsp_data[i*32 +: 32]);
                end
            end
            rsp_valid_prev <= rsp_valid;
        end else begin
            rsp_valid_prev <= '0;
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_sb();
        exp_grant.delete();
        for (int i = 0; i < 4; i++) exp_rsp[i].delete();
    endtask

    task automatic do_reset();
        ARESETN   = 1'b0;
        req_valid = '0;
        rsp_ready = 4'hF;
        en        = 1'b1;
        clear_sb();
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        @(negedge ACLK);
        while (!idle && k < 60) begin
            @(negedge ACLK);
            k++;
        end
        chk(name, {31'b0, idle}, 32'd1);
        @(negedge ACLK);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {28'b0, req_ready}, 32'd0);
        chk({tag, "_core_in_valid"}, {31'b0, core_in_valid}, 32'd0);
        chk({tag, "_core_in_data"}, core_in_data, 32'd0);
        chk({tag, "_rsp_valid"}, {28'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data_or"}, {31'b0, |rsp_data}, 32'd0);
        chk({tag, "_idle"}, {31'b0, idle}, 32'd1);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_jobs_done"}, jobs_done, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, with requests pending to show grants are masked.
        ARESETN   = 1'b0;
        req_valid = 4'hF;
        repeat (2) @(posedge ACLK);
        #1;
        chk_reset_outputs("rst");
        req_valid = '0;
        ARESETN   = 1'b1;

        // 1: single job, check issue timing and result.
        step();
        exp_grant.push_back(4'b0001);
        req_data[31:0] = 32'h4080_0000;
        req_valid      = 4'b0001;
        #1 chk("t1_ready", {28'b0, req_ready}, 32'h1);
        step();
        req_valid = '0;
        chk("t1_core_in_valid", {31'b0, core_in_valid}, 32'd1);
        chk("t1_core_in_data", core_in_data, 32'h4080_0000);
        step();
        chk("t1_core_in_valid_low", {31'b0, core_in_valid}, 32'd0);
        chk("t1_core_in_data_hold", core_in_data, 32'h4080_0000);
        wait_idle("t1_idle");
        chk("t1_jobs_done", jobs_done, 32'd1);

        // 2: all four at once, two rounds.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            exp_grant.push_back(4'b0001);
            exp_grant.push_back(4'b0010);
            exp_grant.push_back(4'b0100);
            exp_grant.push_back(4'b1000);
            req_data  = {32'h3F80_0000 + 32'(r), 32'h4000_0000, 32'h4100_0000, 32'h4280_0000};
            req_valid = 4'hF;
            repeat (4) step();
            req_valid = '0;
            wait_idle("t2_idle");
        end
        chk("t2_jobs_done", jobs_done, 32'd8);
        chk("t2_grants_left", 32'(exp_grant.size()), 32'd0);

        // 3: requester 1 holds its result; others keep rotating.
        do_reset();
        grant_chk = 1'b0;
        rsp_ready = 4'b1101;
        req_data  = {32'h1111_0000, 32'h2222_0000, 32'h5A5A_1234, 32'h0F0F_0F0F};
        req_valid = 4'hF;
        begin
            int k = 0;
            while (!rsp_valid[1] && k < 30) begin
                @(negedge ACLK);
                k++;
            end
        end
        chk("t3_rsp1_valid", {31'b0, rsp_valid[1]}, 32'd1);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("t3_no_regrant1", {31'b0, req_ready[1]}, 32'd0);
            chk("t3_rsp1_stable", rsp_data[63:32], ~32'h5A5A_1234);
        end
        req_valid = 4'b0010;
        rsp_ready = 4'hF;
        step();
        chk("t3_regrant1", {28'b0, req_ready}, 32'h2);
        step();
        req_valid = '0;
        wait_idle("t3_idle");
        grant_chk = 1'b1;

        // 4: en low after two grants drains without new grants.
        do_reset();
        exp_grant.push_back(4'b0001);
        exp_grant.push_back(4'b0010);
        req_data  = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        req_valid = 4'hF;
        step();
        step();
        en = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("t4_no_grant", {28'b0, req_ready}, 32'd0);
            step();
        end
        chk("t4_idle", {31'b0, idle}, 32'd1);
        chk("t4_jobs_done_mid", jobs_done, 32'd2);
        exp_grant.push_back(4'b0100);
        exp_grant.push_back(4'b1000);
        en = 1'b1;
        step();
        step();
        req_valid = '0;
        wait_idle("t4_idle_end");
        chk("t4_jobs_done", jobs_done, 32'd4);

        // 5: reset with jobs in flight; stray results must only raise err.
        do_reset();
        exp_grant.push_back(4'b0001);
        exp_grant.push_back(4'b0010);
        exp_grant.push_back(4'b0100);
        req_data  = {32'h0, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        req_valid = 4'b0111;
        repeat (3) step();
        req_valid = '0;
        ARESETN   = 1'b0;
        #1;
        chk_reset_outputs("t5_rst");
        clear_sb();
        step();
        ARESETN = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t5_no_rsp", {28'b0, rsp_valid}, 32'd0);
        end
        chk("t5_err", {31'b0, err}, 32'd1);
        chk("t5_idle", {31'b0, idle}, 32'd1);
        do_reset();
        chk("t5_err_cleared", {31'b0, err}, 32'd0);

        // 6: jobs_done wraps.
        force dut.jobs_done_reg = 32'hFFFF_FFFF;
        step();
        release dut.jobs_done_reg;
        #1 chk("t6_preload", jobs_done, 32'hFFFF_FFFF);
        exp_grant.push_back(4'b0100);
        req_data[95:64] = 32'h3E80_0000;
        req_valid       = 4'b0100;
        step();
        req_valid = '0;
        wait_idle("t6_idle");
        chk("t6_wrap", jobs_done, 32'd0);
        chk("end_grants_left", 32'(exp_grant.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
